gray_button_debounce_pulse: RTL and testbench
=============================================

Name: gray_button_debounce_pulse

Overview:
- Parametrised, multi-channel successor to the single-button level-to-pulse FSM on the FPGA button input path.
- Each channel:
  - synchronises an asynchronous push-button input;
  - debounces it with a consecutive-sample counter;
  - emits single-cycle pulses on selected edges.
- Outputs drive the Gray counter control logic (step, enable, clear) directly.

Parameters:
- N_CH, 4, number of independent button channels (1..16).
- DB_CYCLES, 4, consecutive synchronised samples required to accept a level change (2..65535). Counter width is clog2(DB_CYCLES+1).
- EDGE_MODE, 0, pulse source:
  - 0 = rising edge of debounced level;
  - 1 = falling edge;
  - 2 = both edges.
- REPEAT_DELAY, 16, cycles after a press before the first auto-repeat pulse. Used only with BTN_REPEAT_EN.
- REPEAT_PERIOD, 4, cycles between subsequent auto-repeat pulses. Used only with BTN_REPEAT_EN.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  N_CH  raw asynchronous button levels, one bit per channel.
- level  out  N_CH  debounced stable level per channel.
- pulse  out  N_CH  single-cycle event per channel.
- any_pulse  out  1  OR of pulse, registered in the same cycle as pulse (no extra latency).

Behaviour:
- Reset:
  - rst is sampled on the rising edge of clk only.
  - While rst=1, all of the following are 0: synchroniser flops, debounce counters, level, pulse, any_pulse. Every channel FSM is in IDLE_LO.
  - Reset mid-debounce abandons the pending change. No pulse is emitted on reset or on the first cycle after reset release.
- Synchroniser:
  - Two flops per channel: btn_in -> s1 -> s2.
  - s2 is the only signal the FSM sees.
- Per-channel FSM, four states:
  - IDLE_LO (level=0):
    - s2=1: go to CHK_HI, cnt=1.
    - Otherwise stay, cnt=0.
  - CHK_HI (level=0):
    - s2=0: go to IDLE_LO, cnt=0. A bounce restarts the count.
    - s2=1 and cnt<DB_CYCLES-1: cnt+1.
    - s2=1 and cnt=DB_CYCLES-1: go to IDLE_HI, level<=1, cnt=0, rise event.
  - IDLE_HI (level=1): mirror of IDLE_LO. s2=0 goes to CHK_LO with cnt=1.
  - CHK_LO (level=1): mirror of CHK_HI. On completion go to IDLE_LO, level<=0, fall event.
- Latency:
  - A clean btn_in change first sampled at edge k appears on s2 after edge k+1.
  - level toggles and pulse asserts on edge k+1+DB_CYCLES.
  - The pulse is high for exactly one cycle.
- Pulse selection:
  - pulse[i] is registered and high for exactly one cycle per accepted event matching EDGE_MODE.
  - Events not matching EDGE_MODE produce no pulse. level still updates.
- Debounce rules:
  - Glitches shorter than DB_CYCLES synchronised cycles never change level and never pulse.
  - Counter saturation is impossible: the count is bounded by DB_CYCLES-1 and cleared on every state exit.
- Channel independence:
  - Channels are fully independent.
  - Simultaneous events on several channels assert the corresponding pulse bits in the same cycle. any_pulse is then 1 for that single cycle.
- Illegal FSM encodings recover to IDLE_LO with cnt=0 and pulse=0 on the next clock.
- The design contains no combinational path from btn_in to any output.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined (auto-repeat logic included):
  - Each channel adds a repeat counter, active only in IDLE_HI.
  - It counts from 0 after the rise event.
  - After REPEAT_DELAY cycles it emits one extra pulse, then repeats every REPEAT_PERIOD cycles while level stays 1.
  - Repeat pulses are emitted in EDGE_MODE 0 and 2 only.
  - Leaving IDLE_HI, including entering CHK_LO, clears the repeat counter and suppresses further repeats. If the release bounces back, the count restarts from 0 and does not resume.
  - rst clears the repeat counter.
- Undefined: no repeat logic is generated; behaviour is exactly as above.

Test Plan:
- Reset behaviour: rst=1 for 3 cycles with btn_in=4'hF, then release -> level=0, pulse=0 during reset. level=4'hF and a single pulse=4'hF appear on cycle 5 after release (EDGE_MODE=0, DB_CYCLES=4).
- Clean press: btn_in[0] 0->1 held, DB_CYCLES=4 -> pulse[0]=1 for exactly one cycle, 5 edges after first sample. level[0]=1 from the same edge. No other pulse bits set.
- Bounce rejection: btn_in[1] toggled 1,0,1,0,1 on successive cycles, then held 1 -> no pulse during the bounce. Exactly one pulse[1] after 4 stable s2=1 samples.
- Both-edges mode: EDGE_MODE=2, press then release btn_in[2] -> two single-cycle pulses. With EDGE_MODE=1, only the release produces a pulse.
- Simultaneous channels: btn_in 4'b0000->4'b1011 in one cycle -> pulse=4'b1011 and any_pulse=1 on one cycle, then 0.
- BTN_REPEAT_EN defined, REPEAT_DELAY=16, REPEAT_PERIOD=4, btn_in[3] held 40 cycles -> initial pulse, then pulses at +16, +20, +24... after the press event. Pulses stop within DB_CYCLES+2 cycles of release.

Source files
------------

// File: rtl/gray_button_debounce_pulse.sv
// Multi-channel push-button front end: 2-flop synchroniser, counting debouncer and edge pulser.
// Optional auto-repeat on held buttons is compiled in when BTN_REPEAT_EN is defined.
module gray_button_debounce_pulse #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned EDGE_MODE     = 0,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pulse,
  output logic            any_pulse
);

  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);

  if (N_CH < 1 || N_CH > 16 || DB_CYCLES < 2 || DB_CYCLES > 65535 || EDGE_MODE > 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("gray_button_debounce_pulse: parameter out of range");
  end

  typedef enum logic [1:0] {StIdleLo, StChkHi, StIdleHi, StChkLo} state_e;

  logic [N_CH-1:0] s1_q, s2_q;
  logic [N_CH-1:0] pulse_d, pulse_q;
  logic            any_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
    end else begin
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      pulse_q <= pulse_d;
      any_q   <= |pulse_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ev_rise, ev_fall, ev_rpt;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= StIdleLo;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Every exit from a state clears the count, so it never exceeds DB_CYCLES-1.
    always_comb begin
      state_d = StIdleLo;
      cnt_d   = '0;
      case (state_q)
        StIdleLo: begin
          if (s2_q[i]) begin
            state_d = StChkHi;
            cnt_d   = CntW'(1);
          end else begin
            state_d = StIdleLo;
          end
        end
        StChkHi: begin
          if (!s2_q[i]) begin
            state_d = StIdleLo;
          end else if (cnt_q == CntW'(DB_CYCLES - 1)) begin
            state_d = StIdleHi;
          end else begin
            state_d = StChkHi;
            cnt_d   = cnt_q + CntW'(1);
          end
        end
        StIdleHi: begin
          if (!s2_q[i]) begin
            state_d = StChkLo;
            cnt_d   = CntW'(1);
          end else begin
            state_d = StIdleHi;
          end
        end
        StChkLo: begin
          if (s2_q[i]) begin
            state_d = StIdleHi;
          end else if (cnt_q == CntW'(DB_CYCLES - 1)) begin
            state_d = StIdleLo;
          end else begin
            state_d = StChkLo;
            cnt_d   = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdleLo;
      endcase
    end

    always_comb begin
      ev_rise = (state_q == StChkHi) && s2_q[i] && (cnt_q == CntW'(DB_CYCLES - 1));
      ev_fall = (state_q == StChkLo) && !s2_q[i] && (cnt_q == CntW'(DB_CYCLES - 1));
      pulse_d[i] = ((EDGE_MODE != 1) && ev_rise) || ((EDGE_MODE != 0) && ev_fall) || ev_rpt;
    end

    assign level[i] = (state_q == StIdleHi) || (state_q == StChkLo);

`ifdef BTN_REPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RptW   = $clog2(RptMax + 1);

    logic [RptW-1:0] rpt_q, rpt_d;
    logic            armed_q, armed_d;
    logic            rpt_fire;

    always_ff @(posedge clk) begin
      if (rst) begin
        rpt_q   <= '0;
        armed_q <= 1'b0;
      end else begin
        rpt_q   <= rpt_d;
        armed_q <= armed_d;
      end
    end

    // Runs only while held in IDLE_HI; any exit drops back to zero and disarms.
    always_comb begin
      rpt_d    = '0;
      armed_d  = 1'b0;
      rpt_fire = 1'b0;
      if (state_q == StIdleHi && s2_q[i]) begin
        if (!armed_q) begin
          if (rpt_q == RptW'(REPEAT_DELAY - 1)) begin
            rpt_fire = 1'b1;
            armed_d  = 1'b1;
          end else begin
            rpt_d = rpt_q + RptW'(1);
          end
        end else begin
          armed_d = 1'b1;
          if (rpt_q == RptW'(REPEAT_PERIOD - 1)) begin
            rpt_fire = 1'b1;
          end else begin
            rpt_d = rpt_q + RptW'(1);
          end
        end
      end
    end

    assign ev_rpt = (EDGE_MODE != 1) && rpt_fire;
`else
    assign ev_rpt = 1'b0;
`endif
  end

  assign pulse     = pulse_q;
  assign any_pulse = any_q;

endmodule

// File: tb/tb_gray_button_debounce_pulse.sv
// Directed bench: three instances share btn_in, one per EDGE_MODE (rise, fall, both).
module tb_gray_button_debounce_pulse;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] lvl0, pl0, lvl1, pl1, lvl2, pl2;
  logic       any0, any1, any2;
  int         ntests = 0;
  int         nfail  = 0;

  always #5 clk = ~clk;

  gray_button_debounce_pulse #(.N_CH(4), .DB_CYCLES(4), .EDGE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .btn_in(btn), .level(lvl0), .pulse(pl0), .any_pulse(any0)
  );
  gray_button_debounce_pulse #(.N_CH(4), .DB_CYCLES(4), .EDGE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .btn_in(btn), .level(lvl1), .pulse(pl1), .any_pulse(any1)
  );
  gray_button_debounce_pulse #(.N_CH(4), .DB_CYCLES(4), .EDGE_MODE(2)) dut2 (
    .clk(clk), .rst(rst), .btn_in(btn), .level(lvl2), .pulse(pl2), .any_pulse(any2)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] bseq [5];
  logic [3:0] exp_rpt;

  initial begin
    // Reset held with all buttons pressed
    rst = 1'b1;
    btn = 4'hF;
    repeat (3) begin
      tick();
      chk("rst_level", lvl0, 4'h0);
      chk("rst_pulse", pl0, 4'h0);
      chk("rst_any", {3'b0, any0}, 4'h0);
    end
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("post_rst_no_pulse", pl0, 4'h0);
      chk("post_rst_level_lo", lvl0, 4'h0);
    end
    tick();
    chk("post_rst_pulse", pl0, 4'hF);
    chk("post_rst_level", lvl0, 4'hF);
    chk("post_rst_any", {3'b0, any0}, 4'h1);
    chk("post_rst_fallmode", pl1, 4'h0);
    chk("post_rst_bothmode", pl2, 4'hF);
    tick();
    chk("post_rst_pulse_end", pl0, 4'h0);
    chk("post_rst_any_end", {3'b0, any0}, 4'h0);
    chk("post_rst_level_hold", lvl0, 4'hF);

    // Release all
    btn = 4'h0;
    repeat (5) begin
      tick();
      chk("relall_level_hold", lvl0, 4'hF);
      chk("relall_no_fall_yet", pl1, 4'h0);
    end
    tick();
    chk("relall_level", lvl0, 4'h0);
    chk("relall_risemode", pl0, 4'h0);
    chk("relall_fallmode", pl1, 4'hF);
    chk("relall_bothmode", pl2, 4'hF);
    tick();
    chk("relall_fall_end", pl1, 4'h0);

    // Clean press on channel 0
    btn = 4'b0001;
    repeat (5) begin
      tick();
      chk("press0_wait", pl0, 4'h0);
    end
    tick();
    chk("press0_pulse", pl0, 4'b0001);
    chk("press0_level", lvl0, 4'b0001);
    chk("press0_any", {3'b0, any0}, 4'h1);
    tick();
    chk("press0_single", pl0, 4'h0);
    chk("press0_level_hold", lvl0, 4'b0001);
    btn = 4'b0000;
    repeat (6) tick();
    chk("rel0_level", lvl0, 4'h0);
    chk("rel0_fallmode", pl1, 4'b0001);
    chk("rel0_risemode", pl0, 4'h0);
    tick();

    // Bounce on channel 1, then held
    bseq = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
    for (int j = 0; j < 5; j++) begin
      btn = bseq[j];
      tick();
      chk("bounce_no_pulse", pl0, 4'h0);
    end
    repeat (4) begin
      tick();
      chk("bounce_settle_no_pulse", pl0, 4'h0);
      chk("bounce_settle_level", lvl0, 4'h0);
    end
    tick();
    chk("bounce_pulse", pl0, 4'b0010);
    chk("bounce_level", lvl0, 4'b0010);
    tick();
    chk("bounce_single", pl0, 4'h0);
    btn = 4'b0000;
    repeat (6) tick();
    chk("bounce_rel_level", lvl0, 4'h0);
    tick();

    // Glitch of 3 cycles (one short of DB_CYCLES) is rejected
    btn = 4'b0001;
    repeat (3) tick();
    btn = 4'b0000;
    repeat (10) begin
      tick();
      chk("glitch_no_pulse", pl0, 4'h0);
      chk("glitch_no_level", lvl0, 4'h0);
    end

    // Simultaneous channels
    btn = 4'b1011;
    repeat (5) tick();
    tick();
    chk("simul_pulse", pl0, 4'b1011);
    chk("simul_any", {3'b0, any0}, 4'h1);
    chk("simul_fallmode", pl1, 4'h0);
    chk("simul_fallmode_any", {3'b0, any1}, 4'h0);
    tick();
    chk("simul_pulse_end", pl0, 4'h0);
    chk("simul_any_end", {3'b0, any0}, 4'h0);
    btn = 4'b0000;
    repeat (5) tick();
    tick();
    chk("simul_rel_fall", pl1, 4'b1011);
    chk("simul_rel_fall_any", {3'b0, any1}, 4'h1);
    chk("simul_rel_both", pl2, 4'b1011);
    chk("simul_rel_rise", pl0, 4'h0);
    tick();
    chk("simul_rel_end", pl1, 4'h0);

    // Both-edges and falling-only on channel 2
    btn = 4'b0100;
    repeat (5) tick();
    tick();
    chk("both_press", pl2, 4'b0100);
    chk("fall_press_none", pl1, 4'h0);
    tick();
    btn = 4'b0000;
    repeat (5) tick();
    tick();
    chk("both_release", pl2, 4'b0100);
    chk("fall_release", pl1, 4'b0100);
    tick();
    chk("both_release_end", pl2, 4'h0);

    // Reset mid-debounce abandons the pending change
    btn = 4'b0001;
    repeat (3) tick();
    rst = 1'b1;
    btn = 4'b0000;
    tick();
    chk("middb_rst_pulse", pl0, 4'h0);
    rst = 1'b0;
    repeat (8) begin
      tick();
      chk("middb_no_pulse", pl0, 4'h0);
      chk("middb_no_level", lvl0, 4'h0);
    end

`ifdef BTN_REPEAT_EN
    // Held channel 3: rise, then repeats at +16, +20, ... until release
    btn = 4'b1000;
    repeat (5) tick();
    tick();
    chk("rpt_rise", pl0, 4'b1000);
    for (int j = 1; j <= 48; j++) begin
      if (j == 41) btn = 4'b0000;
      tick();
      exp_rpt = (j >= 16 && j <= 42 && ((j - 16) % 4) == 0) ? 4'b1000 : 4'b0000;
      chk("rpt_risemode", pl0, exp_rpt);
      chk("rpt_fallmode", pl1, (j == 46) ? 4'b1000 : 4'b0000);
    end
    chk("rpt_level_end", lvl0, 4'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
